// File: rtl/lsu_ctrl.sv
// Load/store unit between the core data port and a single-ported word-wide memory.
// Build option LSU_MISALIGN_SPLIT_EN: split misaligned half/word accesses instead of rejecting them.
module lsu_ctrl #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    localparam logic [1:0] SizeB = 2'b00;
    localparam logic [1:0] SizeH = 2'b01;
    localparam logic [1:0] SizeW = 2'b10;
    localparam logic [1:0] SizeX = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_WAIT, S_WR0, S_WR1, S_RSP
    } state_e;

    state_e state_q, state_d;

    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              split_q, split_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       hi_q, hi_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [1:0]  in_off;
    logic        in_mis, in_err, in_split, in_wstore;
    logic [4:0]  shamt;
    logic [63:0] pair, ext_pair, lane_mask, wd_sh, merged;
    logic [31:0] w0, l32, load_data;
    logic        unused_bits;

    // Request decode on the raw core inputs (only meaningful in IDLE)
    always_comb begin
        in_off    = req_addr[1:0];
        in_mis    = ((req_size == SizeH) && (in_off == 2'd3)) ||
                    ((req_size == SizeW) && (in_off != 2'd0));
        in_err    = (req_size == SizeX) || (in_mis && !SplitEn);
        in_split  = in_mis && SplitEn;
        in_wstore = req_we && (req_size == SizeW) && (in_off == 2'd0);
    end

    // Byte-lane alignment: the addressed bytes sit in the 64-bit window {second word, first word}
    always_comb begin
        shamt    = {off_q, 3'b000};
        w0       = split_q ? lo_q : mem_rdata;
        pair     = {mem_rdata, w0};
        ext_pair = pair >> shamt;
        l32      = ext_pair[31:0];
        case (size_q)
            SizeB:   lane_mask = 64'h0000_0000_0000_00FF;
            SizeH:   lane_mask = 64'h0000_0000_0000_FFFF;
            default: lane_mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        lane_mask = lane_mask << shamt;
        wd_sh     = {32'd0, wdata_q} << shamt;
        merged    = (pair & ~lane_mask) | (wd_sh & lane_mask);
        case (size_q)
            SizeB:   load_data = {{24{~uns_q & l32[7]}}, l32[7:0]};
            SizeH:   load_data = {{16{~uns_q & l32[15]}}, l32[15:0]};
            default: load_data = l32;
        endcase
    end

    assign unused_bits = ^{req_addr[31:ADDR_W+2], ext_pair[63:32]};

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        uns_d       = uns_q;
        split_d     = split_q;
        size_d      = size_q;
        off_d       = off_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    split_d = in_split;
                    size_d  = req_size;
                    off_d   = in_off;
                    idx_d   = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    if (in_err) begin
                        state_d = S_RSP;
                    end else if (in_wstore) begin
                        state_d = S_WR0;
                    end else begin
                        state_d = S_RD0;
                    end
                end
            end
            S_RD0:  state_d = split_q ? S_RD1 : S_WAIT;
            S_RD1: begin
                lo_d    = mem_rdata;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (we_q) begin
                    hi_d    = merged[63:32];
                    state_d = S_WR0;
                end else begin
                    state_d = S_RSP;
                end
            end
            S_WR0:  state_d = split_q ? S_WR1 : S_RSP;
            S_WR1:  state_d = S_RSP;
            S_RSP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered as a function of the state being entered
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP);
        rsp_err_d   = (state_q == S_IDLE) && (state_d == S_RSP);
        if ((state_q == S_WAIT) && (state_d == S_RSP)) begin
            rsp_rdata_d = load_data;
        end
        mem_re_d = (state_d == S_RD0) || (state_d == S_RD1);
        mem_we_d = (state_d == S_WR0) || (state_d == S_WR1);
        case (state_d)
            S_RD0: mem_addr_d = idx_d;
            S_RD1: mem_addr_d = idx_d + ADDR_W'(1);
            S_WR0: begin
                mem_addr_d  = idx_d;
                mem_wdata_d = (state_q == S_IDLE) ? req_wdata : merged[31:0];
            end
            S_WR1: begin
                mem_addr_d  = idx_d + ADDR_W'(1);
                mem_wdata_d = hi_q;
            end
            default: begin
                mem_addr_d  = '0;
                mem_wdata_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            lo_q        <= 32'd0;
            hi_q        <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            split_q     <= split_d;
            size_q      <= size_d;
            off_q       <= off_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
